instr_fetch: RTL and testbench

Instruction fetch and instruction-register stage of the P2 datapath. It holds the program counter, fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, and latches each word in the instruction register (IR). It presents the IR and its decoded fields to decode, including the 16-bit immediate `imm16` that drives the `signextend` stage directly.

---
 rtl/p2_pkg.sv | 34 +++
 rtl/ir_fields.sv | 19 +
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/p2_pkg.sv
// Shared definitions for the P2 datapath: fetch FSM states, instruction
// field positions and fetch constants.
package p2_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned PC_STEP = 4;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ir_fields.sv
// Combinational split of an instruction word into its decode fields.
module ir_fields
  import p2_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16
);

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign imm16  = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch / IR stage: PC, request-acknowledge fetch from imem,
// instruction register with valid/ready hand-off to decode, and redirects.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (sticky misaligned-redirect flag).
module instr_fetch
  import p2_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc_out,
  output logic        align_err
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drop_addr;
  logic [31:0]  redirect_target;

  assign redirect_target = align_pc(redirect_pc);

  // Request is a pure function of state; DROP re-presents the abandoned address.
  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  // Fetch FSM with PC, IR and hand-off registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= '0;
      ir        <= '0;
      pc_out    <= '0;
      ir_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ir_valid <= 1'b0;
          state    <= REQ;
        end
        REQ: begin
          if (redirect_en) begin
            pc <= redirect_target;
            if (!imem_ack) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            pc_out   <= pc;
            pc       <= pc + 32'(PC_STEP);
            ir_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_en) begin
            pc       <= redirect_target;
            ir_valid <= 1'b0;
            state    <= REQ;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= REQ;
          end
        end
        DROP: begin
          if (redirect_en) begin
            pc <= redirect_target;
          end
          if (imem_ack) begin
            state <= REQ;
          end
        end
        default: begin
          ir_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky flag for any accepted redirect with nonzero low address bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else if (redirect_en && (state != IDLE) && (redirect_pc[1:0] != 2'b00)) begin
      align_err <= 1'b1;
    end
  end
`else
  assign align_err = 1'b0;
`endif

  ir_fields u_ir_fields (
    .ir     (ir),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm16  (imm16)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fetch scoreboard.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] pc_out;
  logic        align_err;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] AE_EXP = 32'd1;
`else
  localparam logic [31:0] AE_EXP = 32'd0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          last_wait = 0;
  logic [31:0] last_ir = 32'h0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ir          (ir),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm16       (imm16),
    .pc_out      (pc_out),
    .align_err   (align_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, then check its address.
  task automatic wait_req(input logic [31:0] exp_addr);
    int i;
    for (i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    last_wait = i;
    check("req", 32'(imem_req), 32'd1);
    check("req_addr", imem_addr, exp_addr);
    check("valid_in_req", 32'(ir_valid), 32'd0);
  endtask

  // Acknowledge one fetch, then compare the IR against the scoreboard.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic rdy);
    sb_t e;
    wait_req(addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    ir_ready   = rdy;
    sb.push_back({addr, data});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("valid", 32'(ir_valid), 32'd1);
    check("req_in_hold", 32'(imem_req), 32'd0);
    e = sb.pop_front();
    check("ir", ir, e.data);
    check("pc_out", pc_out, e.addr);
    last_ir = e.data;
  endtask

  // Ack the current request while redirecting; data must be discarded.
  task automatic ack_redirect(input logic [31:0] target, input logic [31:0] exp_next);
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    redirect_en = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    imem_ack    = 1'b0;
    redirect_en = 1'b0;
    check("redir_ir", ir, last_ir);
    check("redir_valid", 32'(ir_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, exp_next);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    ir_ready    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", ir, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_align", 32'(align_err), 32'd0);

    // First request appears in the second cycle after release
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h100);

    // Back-to-back fetches with decode always ready
    fetch(32'h100, 32'h1111_0001, 1'b1);
    fetch(32'h104, 32'h2222_0002, 1'b1);
    check("gap1", 32'(last_wait), 32'd1);
    fetch(32'h108, 32'h3333_0003, 1'b1);
    check("gap2", 32'(last_wait), 32'd1);

    // Stall: IR and fields stable while decode is not ready
    fetch(32'h10C, 32'h2008_FFFC, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ir", ir, 32'h2008_FFFC);
      check("stall_valid", 32'(ir_valid), 32'd1);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    check("opcode", 32'(opcode), 32'h08);
    check("rs", 32'(rs), 32'd0);
    check("rt", 32'(rt), 32'd8);
    check("rd", 32'(rd), 32'd31);
    check("imm16", 32'(imm16), 32'hFFFC);
    check("stall_pc_out", pc_out, 32'h10C);
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    wait_req(32'h110);

    // Ack with simultaneous redirect moves the fetch to 0x200
    ack_redirect(32'h200, 32'h200);

    // Redirect without ack: outstanding address held until acked
    redirect_en = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("drop_req", 32'(imem_req), 32'd1);
      check("drop_addr", imem_addr, 32'h200);
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hBADB_AD00;
    @(negedge clk);
    imem_ack = 1'b0;
    check("drop_ir", ir, last_ir);
    check("drop_valid", 32'(ir_valid), 32'd0);
    fetch(32'h400, 32'hAAAA_0001, 1'b0);

    // Redirect from HOLD drops the IR
    redirect_en = 1'b1;
    redirect_pc = 32'h208;
    @(negedge clk);
    redirect_en = 1'b0;
    check("hold_redir_valid", 32'(ir_valid), 32'd0);
    wait_req(32'h208);

    // Ack at 0x208 with redirect to 0x300: IR not written
    ack_redirect(32'h300, 32'h300);

    // PC wrap at the top of the address space
    ack_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'hCAFE_0001, 1'b1);
    fetch(32'h0000_0000, 32'hCAFE_0002, 1'b1);
    wait_req(32'h4);

    // Misaligned redirect is forced aligned; flag is sticky when enabled
    ack_redirect(32'h402, 32'h400);
    check("align_set", 32'(align_err), AE_EXP);
    ack_redirect(32'h500, 32'h500);
    check("align_sticky", 32'(align_err), AE_EXP);

    // Reset mid-fetch with ack held: ack ignored until REQ
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    rst_n      = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_ir", ir, 32'h0);
    check("mid_rst_align", 32'(align_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ir", ir, 32'h0);
    check("post_rst_valid", 32'(ir_valid), 32'd0);
    imem_ack = 1'b0;
    last_ir  = 32'h0;
    fetch(32'h100, 32'h5555_AAAA, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
